mrc_digit_sequencer: RTL and testbench
======================================

Name: mrc_digit_sequencer

Overview:
- Mixed-radix conversion (MRC) controller for one RNS word of NUM_DIGITS residues.
- Upstream: accepts the full residue word with a valid/ready handshake.
- Drives a bank of external subtract-then-multiply-by-inverse units (one lane per residue) with an operand/digit broadcast, then captures their results after a fixed pipeline latency.
- Iterates NUM_DIGITS-1 steps and emits the mixed-radix digit vector downstream, also with valid/ready.

Parameters:
- DATA_WIDTH, 18, width of one residue/digit.
- NUM_DIGITS, 8, residues per RNS word; legal range 2..16.
- SIM_LATENCY, 7, clk cycles from operand issue to a valid lane result; must be 1 or more.
- TOP_HALF, 65536, threshold on the last digit for sign detection (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_res  in  NUM_DIGITS*DATA_WIDTH  residues; lane j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
- sim_a_out  out  NUM_DIGITS*DATA_WIDTH  per-lane minuend (current residue r_j).
- sim_b_out  out  DATA_WIDTH  broadcast subtrahend (current digit d_i).
- sim_step  out  4  step index i; lanes use it to select their inverse table.
- sim_issue  out  1  one-cycle strobe marking valid operands.
- sim_res_in  in  NUM_DIGITS*DATA_WIDTH  lane results, (r_j - d_i)*inv(m_i) mod m_j.
- out_valid  out  1  digit vector valid.
- out_ready  in  1  downstream accepts.
- out_digits  out  NUM_DIGITS*DATA_WIDTH  mixed-radix digits d_0..d_{N-1}, same lane packing as in_res.
- out_neg  out  1  sign flag (optional feature only).

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE, in_ready=1, out_valid=0, sim_issue=0, sim_step=0, sim_a_out=0, sim_b_out=0, out_digits=0, out_neg=0. A reset mid-operation abandons the word with no output; lane results still in flight are ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load r[] from in_res, set step i=0, go to ISSUE.
- ISSUE (one cycle):
  - sim_issue=1, sim_b_out=r[i], sim_a_out=r[], sim_step=i.
  - Latch digit d_i=r[i].
  - Clear the wait counter, go to WAIT.
- WAIT:
  - Counter runs 1..SIM_LATENCY.
  - At count==SIM_LATENCY, in that cycle: r[j] <= sim_res_in lane j for all j>i; lanes j<=i are held.
  - Then, if i==NUM_DIGITS-2: set d_{N-1}=new r[N-1] and go to DONE. Otherwise i<=i+1 and go to ISSUE.
- DONE:
  - out_valid=1; out_digits holds d[] stable.
  - On out_ready: go to IDLE. in_ready rises the cycle after the handshake, so no same-cycle accept.
- Latency: the accept handshake at cycle t gives out_valid at t+1+(NUM_DIGITS-1)*(SIM_LATENCY+1). With NUM_DIGITS=3, SIM_LATENCY=7 this is t+17.
- in_ready=0 in ISSUE, WAIT and DONE. in_valid is ignored there and in_res is not sampled.
- sim_a_out and sim_b_out hold their last values outside ISSUE; lanes must qualify with sim_issue.
- Lane 0 result is never consumed.
- No modular arithmetic is done in this block; widths pass through unchanged.

Optional Feature:
- Macro: MRC_SIGN_DETECT_EN.
- Defined: out_neg = (d_{N-1} >= TOP_HALF), registered alongside out_valid and held through DONE.
- Undefined: out_neg is tied to 0 and the comparator logic is absent.

Decomposition:
- Shared package mrc_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - STEP_W=4;
  - lane-slice helper function (lane j of a packed vector).
- One natural sub-module, mrc_wait_counter: loadable down-counter with a terminal strobe, sized by SIM_LATENCY.

Test Plan:
- Bench lane models use moduli {7,11,13}, NUM_DIGITS=3, SIM_LATENCY=7.
- X=100, in_res={2,1,9} -> out_digits={2,3,1} (2+7*3+77*1=100), out_valid at accept+17, exactly 2 sim_issue pulses with sim_step=0 then 1.
- X=0, in_res={0,0,0} -> out_digits={0,0,0}; X=1000 (mod 1001 range), in_res={6,10,12} -> out_digits={6,10,12}.
- out_ready held low 20 cycles in DONE -> out_valid and out_digits stable; in_ready=0 throughout; a second in_valid is not accepted until the cycle after the out handshake.
- reset asserted during WAIT of step 1 -> next cycle IDLE, in_ready=1, out_valid=0; a new word X=5 then converts correctly to {5,0,0}.
- MRC_SIGN_DETECT_EN defined, TOP_HALF=7: X=1000 gives out_neg=1, X=100 gives out_neg=0; undefined: out_neg=0 always.

Source files
------------

// File: rtl/mrc_pkg.sv
// Shared types and helpers for the mixed-radix conversion sequencer.
package mrc_pkg;

    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } mrc_state_e;

    // Bit offset of lane j inside a packed vector of width-bit lanes.
    function automatic int lane_base(input int j, input int width);
        return j * width;
    endfunction

endpackage

// File: rtl/mrc_wait_counter.sv
// Loadable down-counter that strobes 'done' on the last cycle of a LATENCY-cycle wait.
module mrc_wait_counter #(
    parameter int LATENCY = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LATENCY);
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // A loaded value of LATENCY reaches 1 on the LATENCY-th enabled cycle.
    assign done = enable && (count == CNT_W'(1));

endmodule

// File: rtl/mrc_digit_sequencer.sv
// Mixed-radix conversion controller: sequences external per-lane subtract/multiply units.
// Optional sign flag on the top digit is enabled by defining MRC_SIGN_DETECT_EN.
module mrc_digit_sequencer
    import mrc_pkg::*;
#(
    parameter int DATA_WIDTH  = 18,
    parameter int NUM_DIGITS  = 8,
    parameter int SIM_LATENCY = 7,
    parameter int TOP_HALF    = 65536
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_DIGITS*DATA_WIDTH-1:0] in_res,
    output logic [NUM_DIGITS*DATA_WIDTH-1:0] sim_a_out,
    output logic [DATA_WIDTH-1:0]            sim_b_out,
    output logic [STEP_W-1:0]                sim_step,
    output logic                             sim_issue,
    input  logic [NUM_DIGITS*DATA_WIDTH-1:0] sim_res_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_DIGITS*DATA_WIDTH-1:0] out_digits,
    output logic                             out_neg
);

    localparam int VEC_W    = NUM_DIGITS * DATA_WIDTH;
    localparam int LAST_LSB = (NUM_DIGITS - 1) * DATA_WIDTH;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_DIGITS - 2);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
        $error("NUM_DIGITS must be in 2..16");
    end
    if (SIM_LATENCY < 1) begin : g_bad_latency
        $error("SIM_LATENCY must be at least 1");
    end
    if (TOP_HALF < 1) begin : g_bad_top_half
        $error("TOP_HALF must be positive");
    end

    mrc_state_e        state;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] next_step;
    logic [VEC_W-1:0]  r;
    logic [VEC_W-1:0]  d;
    logic [VEC_W-1:0]  r_next;
    logic [VEC_W-1:0]  d_final;
    logic              wait_done;

`ifdef MRC_SIGN_DETECT_EN
    localparam logic [DATA_WIDTH:0] TOP_HALF_W = (DATA_WIDTH + 1)'(TOP_HALF);
    logic neg_q;
    assign out_neg = neg_q;
`else
    assign out_neg = 1'b0;
`endif

    assign next_step = step + STEP_W'(1);

    mrc_wait_counter #(
        .LATENCY(SIM_LATENCY)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .load  (state == ISSUE),
        .enable(state == WAIT),
        .done  (wait_done)
    );

    // Lanes above the current step take the fresh lane result; lower lanes are already final.
    always_comb begin
        r_next = r;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j > int'(step)) begin
                r_next[lane_base(j, DATA_WIDTH) +: DATA_WIDTH] =
                    sim_res_in[lane_base(j, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
        d_final = d;
        d_final[LAST_LSB +: DATA_WIDTH] = r_next[LAST_LSB +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            step       <= '0;
            r          <= '0;
            d          <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_digits <= '0;
            sim_issue  <= 1'b0;
            sim_step   <= '0;
            sim_a_out  <= '0;
            sim_b_out  <= '0;
`ifdef MRC_SIGN_DETECT_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            sim_issue <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r         <= in_res;
                        step      <= '0;
                        sim_a_out <= in_res;
                        sim_b_out <= in_res[0 +: DATA_WIDTH];
                        sim_step  <= '0;
                        sim_issue <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    d[lane_base(int'(step), DATA_WIDTH) +: DATA_WIDTH] <=
                        r[lane_base(int'(step), DATA_WIDTH) +: DATA_WIDTH];
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_done) begin
                        r <= r_next;
                        if (step == LAST_STEP) begin
                            d          <= d_final;
                            out_digits <= d_final;
                            out_valid  <= 1'b1;
`ifdef MRC_SIGN_DETECT_EN
                            neg_q <= ({1'b0, r_next[LAST_LSB +: DATA_WIDTH]} >= TOP_HALF_W);
`endif
                            state <= DONE;
                        end else begin
                            step      <= next_step;
                            sim_step  <= next_step;
                            sim_a_out <= r_next;
                            sim_b_out <= r_next[lane_base(int'(next_step), DATA_WIDTH) +: DATA_WIDTH];
                            sim_issue <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    // in_ready returns only after the output handshake edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mrc_digit_sequencer.sv
// Directed bench for mrc_digit_sequencer with moduli {7,11,13}; honours MRC_SIGN_DETECT_EN.
module tb_mrc_digit_sequencer;

    localparam int DW    = 18;
    localparam int ND    = 3;
    localparam int LAT   = 7;
    localparam int VEC_W = ND * DW;
`ifdef MRC_SIGN_DETECT_EN
    localparam bit SIGN_ON = 1'b1;
`else
    localparam bit SIGN_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_res;
    logic [VEC_W-1:0] sim_a_out;
    logic [DW-1:0]    sim_b_out;
    logic [3:0]       sim_step;
    logic             sim_issue;
    logic [VEC_W-1:0] sim_res_in;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_digits;
    logic             out_neg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int issue_count = 0;
    logic [3:0] issue_steps [8];

    logic [VEC_W-1:0] junk;
    logic [VEC_W-1:0] pipe [LAT];

    mrc_digit_sequencer #(
        .DATA_WIDTH (DW),
        .NUM_DIGITS (ND),
        .SIM_LATENCY(LAT),
        .TOP_HALF   (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .sim_a_out (sim_a_out),
        .sim_b_out (sim_b_out),
        .sim_step  (sim_step),
        .sim_issue (sim_issue),
        .sim_res_in(sim_res_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digits(out_digits),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Lane model: (r_j - d_i) * inv(m_i) mod m_j for j > i; all other lanes carry junk.
    function automatic logic [VEC_W-1:0] lane_model(input logic [VEC_W-1:0] a,
                                                    input logic [DW-1:0] b,
                                                    input logic [3:0] s);
        int m [3];
        int mi, mj, rv, dv, inv;
        logic [VEC_W-1:0] res;
        m[0] = 7; m[1] = 11; m[2] = 13;
        res = {VEC_W{1'b1}};
        for (int j = 0; j < ND; j++) begin
            if (j > int'(s) && int'(s) < ND) begin
                mi  = m[int'(s)];
                mj  = m[j];
                rv  = int'(a[j*DW +: DW]);
                dv  = int'(b);
                inv = 0;
                for (int k = 1; k < mj; k++) if ((mi * k) % mj == 1) inv = k;
                res[j*DW +: DW] = DW'((((rv - (dv % mj) + mj) % mj) * inv) % mj);
            end
        end
        return res;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= sim_issue ? lane_model(sim_a_out, sim_b_out, sim_step) : {VEC_W{1'b1}};
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign sim_res_in = pipe[LAT-1];

    always @(negedge clk) begin
        if (sim_issue) begin
            if (issue_count < 8) issue_steps[issue_count] = sim_step;
            issue_count = issue_count + 1;
        end
    end

    function automatic logic [VEC_W-1:0] pack3(input int l2, input int l1, input int l0);
        return {DW'(l2), DW'(l1), DW'(l0)};
    endfunction

    task automatic send_word(input logic [VEC_W-1:0] word, output int t0);
        bit ok;
        ok = 1'b0;
        t0 = 0;
        @(posedge clk); #1;
        in_res   = word;
        in_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                t0 = cyc;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL accept: in_ready=%b never seen, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_res   = junk;
    endtask

    task automatic await_output(input int t0, input string name, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok  = 1'b1;
                lat = cyc - t0;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s_out_valid: out_valid=%b after timeout, required 1", name, out_valid);
        end
    endtask

    task automatic check_result(input string name, input logic [VEC_W-1:0] exp_digits,
                                input logic exp_neg, input int lat);
        checks++;
        if (out_digits !== exp_digits) begin
            errors++;
            $display("[TB] FAIL %s_digits: got {%0d,%0d,%0d} required {%0d,%0d,%0d}", name,
                     out_digits[2*DW +: DW], out_digits[DW +: DW], out_digits[0 +: DW],
                     exp_digits[2*DW +: DW], exp_digits[DW +: DW], exp_digits[0 +: DW]);
        end
        checks++;
        if (out_neg !== exp_neg) begin
            errors++;
            $display("[TB] FAIL %s_neg: got %b required %b", name, out_neg, exp_neg);
        end
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d required 17", name, lat);
        end
    endtask

    task automatic release_output(input string name);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_ready_in_handshake: in_ready=%b required 0", name, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_res    = junk;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sim_issue !== 1'b0 || out_neg !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: in_ready=%b out_valid=%b sim_issue=%b out_neg=%b required 1/0/0/0",
                     in_ready, out_valid, sim_issue, out_neg);
        end
        checks++;
        if (sim_step !== 4'd0 || sim_b_out !== '0 || sim_a_out !== '0 || out_digits !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: sim_step=%0d sim_b=%0d sim_a=%h digits=%h required all 0",
                     sim_step, sim_b_out, sim_a_out, out_digits);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_convert_100;
        int t0, lat;
        issue_count = 0;
        send_word(pack3(9, 1, 2), t0);
        await_output(t0, "x100", lat);
        check_result("x100", pack3(1, 3, 2), 1'b0, lat);
        checks++;
        if (issue_count !== 2) begin
            errors++;
            $display("[TB] FAIL x100_issue_count: got %0d required 2", issue_count);
        end
        checks++;
        if (issue_steps[0] !== 4'd0 || issue_steps[1] !== 4'd1) begin
            errors++;
            $display("[TB] FAIL x100_issue_steps: got %0d,%0d required 0,1", issue_steps[0], issue_steps[1]);
        end
        release_output("x100");
    endtask

    task automatic test_convert_edges;
        int t0, lat;
        send_word(pack3(0, 0, 0), t0);
        await_output(t0, "x0", lat);
        check_result("x0", pack3(0, 0, 0), 1'b0, lat);
        release_output("x0");
        send_word(pack3(12, 10, 6), t0);
        await_output(t0, "x1000", lat);
        check_result("x1000", pack3(12, 10, 6), SIGN_ON, lat);
        release_output("x1000");
    endtask

    task automatic test_back_to_back;
        int t0, lat;
        logic [VEC_W-1:0] held;
        bit bad;
        send_word(pack3(12, 10, 6), t0);
        await_output(t0, "bp_first", lat);
        check_result("bp_first", pack3(12, 10, 6), SIGN_ON, lat);
        held = out_digits;
        bad  = 1'b0;
        @(posedge clk); #1;
        in_res   = pack3(9, 1, 2);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_digits !== held || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL bp_hold: out_valid=%b in_ready=%b digits=%h required 1/0/%h",
                     out_valid, in_ready, out_digits, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_same_cycle_accept: in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_reaccept: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        t0 = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_res   = junk;
        await_output(t0, "bp_second", lat);
        check_result("bp_second", pack3(1, 3, 2), 1'b0, lat);
        release_output("bp_second");
    endtask

    task automatic test_reset_mid_op;
        int t0, lat;
        bit seen, bad;
        send_word(pack3(12, 10, 6), t0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sim_issue === 1'b1 && sim_step === 4'd1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL midrst_step1: sim_step=%0d never issued, required 1", sim_step);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_digits !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_idle: in_ready=%b out_valid=%b digits=%h required 1/0/0",
                     in_ready, out_valid, out_digits);
        end
        bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL midrst_no_output: out_valid=%b required 0", out_valid);
        end
        send_word(pack3(5, 5, 5), t0);
        await_output(t0, "x5", lat);
        check_result("x5", pack3(0, 0, 5), 1'b0, lat);
        release_output("x5");
    endtask

    initial begin
        junk = {3{18'h2A5A5}};
        $display("[TB] start, sign detect=%0d", SIGN_ON);
        test_reset();
        test_convert_100();
        test_convert_edges();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
